// File: rtl/r_i_pkg.sv
// Shared encodings for the R/I-type sequencer: FSM states, opcode/funct values,
// ALU operation codes and the fixed cycles-per-instruction.
package r_i_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_WB     = 3'b100,
    S_HALT   = 3'b101
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int CPI = 4;

endpackage

// File: rtl/r_i_op_decode.sv
// Combinational opcode/funct decoder: ALU control, operand/immediate selects,
// destination select, legality and whether the op can raise an overflow trap.
module r_i_op_decode
  import r_i_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       alu_bsel,
  output logic       imm_sext,
  output logic       rf_wsel,
  output logic       legal,
  output logic       ovf_chk
);

  always_comb begin
    alu_op   = ALU_ADD;
    alu_bsel = 1'b0;
    imm_sext = 1'b0;
    rf_wsel  = 1'b0;
    legal    = 1'b0;
    ovf_chk  = 1'b0;
    if (opcode == OP_RTYPE) begin
      legal = 1'b1;
      case (funct)
        FN_ADD:  begin alu_op = ALU_ADD; ovf_chk = 1'b1; end
        FN_SUB:  begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_XOR:  alu_op = ALU_XOR;
        FN_NOR:  alu_op = ALU_NOR;
        FN_SLT:  alu_op = ALU_SLT;
        default: legal = 1'b0;
      endcase
    end else begin
      legal    = 1'b1;
      alu_bsel = 1'b1;
      rf_wsel  = 1'b1;
      case (opcode)
        OP_ADDI: begin alu_op = ALU_ADD; imm_sext = 1'b1; ovf_chk = 1'b1; end
        OP_SLTI: begin alu_op = ALU_SLT; imm_sext = 1'b1; end
        OP_ANDI: alu_op = ALU_AND;
        OP_ORI:  alu_op = ALU_OR;
        OP_XORI: alu_op = ALU_XOR;
        default: begin legal = 1'b0; alu_bsel = 1'b0; rf_wsel = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/r_i_seq_ctrl.sv
// Multi-cycle R/I-type control sequencer (FETCH/DECODE/EXEC/WB) with sticky illegal
// and retired-instruction count. Optional OVERFLOW_TRAP_EN halts on ADD/SUB/ADDI overflow.
module r_i_seq_ctrl
  import r_i_pkg::*;
(
  input  logic        clka,
  input  logic        rsta,
  input  logic        run,
  input  logic [31:0] inst,
  input  logic        ofa,
  input  logic        zfa,
  output logic        pc_we,
  output logic        ir_we,
  output logic [2:0]  alu_op,
  output logic        alu_bsel,
  output logic        imm_sext,
  output logic        rf_wsel,
  output logic        rf_we,
  output logic        flag_we,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [15:0] instret
);

  state_e     st;
  logic [5:0] opc_q, fn_q, d_opc, d_fn;
  logic [2:0] d_alu_op;
  logic       d_bsel, d_sext, d_wsel, d_legal, d_ovf;
  logic       trap, trap_q, unused;

  // DECODE sees the live instruction; later states use the latched copy.
  assign d_opc = (st == S_DECODE) ? inst[31:26] : opc_q;
  assign d_fn  = (st == S_DECODE) ? inst[5:0]   : fn_q;
  assign state = st;

  r_i_op_decode u_dec (
    .opcode   (d_opc),
    .funct    (d_fn),
    .alu_op   (d_alu_op),
    .alu_bsel (d_bsel),
    .imm_sext (d_sext),
    .rf_wsel  (d_wsel),
    .legal    (d_legal),
    .ovf_chk  (d_ovf)
  );

`ifdef OVERFLOW_TRAP_EN
  assign trap   = d_ovf & ofa;
  assign unused = ^{zfa, inst[25:6]};
`else
  assign trap   = 1'b0;
  assign unused = ^{zfa, ofa, d_ovf, inst[25:6]};
`endif

  always_ff @(posedge clka) begin
    if (rsta) begin
      st       <= S_IDLE;
      opc_q    <= '0;
      fn_q     <= '0;
      trap_q   <= 1'b0;
      pc_we    <= 1'b0;
      ir_we    <= 1'b0;
      alu_op   <= ALU_ADD;
      alu_bsel <= 1'b0;
      imm_sext <= 1'b0;
      rf_wsel  <= 1'b0;
      rf_we    <= 1'b0;
      flag_we  <= 1'b0;
      illegal  <= 1'b0;
      instret  <= '0;
    end else begin
      case (st)
        S_IDLE: if (run) begin
          st    <= S_FETCH;
          ir_we <= 1'b1;
          pc_we <= 1'b1;
        end
        S_FETCH: begin
          ir_we <= 1'b0;
          pc_we <= 1'b0;
          st    <= run ? S_DECODE : S_IDLE;
        end
        S_DECODE: begin
          opc_q <= inst[31:26];
          fn_q  <= inst[5:0];
          if (d_legal) begin
            st       <= S_EXEC;
            alu_op   <= d_alu_op;
            alu_bsel <= d_bsel;
            imm_sext <= d_sext;
            rf_wsel  <= d_wsel;
            flag_we  <= 1'b1;
          end else begin
            st      <= S_HALT;
            illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          st      <= S_WB;
          flag_we <= 1'b0;
          trap_q  <= trap;
          rf_we   <= ~trap;
        end
        S_WB: begin
          rf_we    <= 1'b0;
          alu_op   <= ALU_ADD;
          alu_bsel <= 1'b0;
          imm_sext <= 1'b0;
          rf_wsel  <= 1'b0;
          trap_q   <= 1'b0;
          if (trap_q) begin
            st      <= S_HALT;
            illegal <= 1'b1;
          end else begin
            // Fetch strobes only fire if run is still up; a stopping core
            // passes through FETCH without loading a new instruction.
            st      <= S_FETCH;
            instret <= instret + 16'd1;
            ir_we   <= run;
            pc_we   <= run;
          end
        end
        default: begin
          st      <= S_HALT;
          pc_we   <= 1'b0;
          ir_we   <= 1'b0;
          rf_we   <= 1'b0;
          flag_we <= 1'b0;
          alu_op  <= ALU_ADD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_r_i_seq_ctrl.sv
// Self-checking bench for r_i_seq_ctrl: directed scenarios plus randomized
// instruction streams checked against a table-driven instruction model.
module tb_r_i_seq_ctrl;

  logic        clka = 1'b0;
  logic        rsta, run, ofa, zfa;
  logic [31:0] inst;
  logic        pc_we, ir_we, alu_bsel, imm_sext, rf_wsel, rf_we, flag_we, illegal;
  logic [2:0]  alu_op, state;
  logic [15:0] instret;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_ret;

`ifdef OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  r_i_seq_ctrl dut (
    .clka(clka), .rsta(rsta), .run(run), .inst(inst), .ofa(ofa), .zfa(zfa),
    .pc_we(pc_we), .ir_we(ir_we), .alu_op(alu_op), .alu_bsel(alu_bsel),
    .imm_sext(imm_sext), .rf_wsel(rf_wsel), .rf_we(rf_we), .flag_we(flag_we),
    .state(state), .illegal(illegal), .instret(instret)
  );

  always #5 clka = ~clka;

  typedef struct packed {
    logic       rt;
    logic [5:0] opc;
    logic [5:0] fn;
    logic [2:0] op;
    logic       bsel;
    logic       sext;
    logic       wsel;
    logic       ovc;
  } ent_t;

  ent_t tbl[$];

  function automatic bit lookup(input logic [31:0] i, output ent_t e);
    e = '0;
    foreach (tbl[k])
      if (tbl[k].opc == i[31:26] && (!tbl[k].rt || tbl[k].fn == i[5:0])) begin
        e = tbl[k];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // enables packed as {pc_we, ir_we, flag_we, rf_we}
  task automatic chk_en(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, pc_we, ir_we, flag_we, rf_we}, {28'd0, exp});
  endtask

  task automatic do_reset();
    rsta = 1'b1; run = 1'b0; ofa = 1'b0;
    step();
    rsta = 1'b0;
    exp_ret = '0;
    chk("rst.state", state, 0);
    chk("rst.illegal", illegal, 0);
    chk("rst.instret", instret, 0);
    chk("rst.alu_op", alu_op, 3'b010);
    chk_en("rst.en", 4'b0000);
  endtask

  // Drives one instruction from IDLE or end-of-WB; returns halted=1 if it ended in HALT.
  task automatic do_inst(input logic [31:0] iv, input logic ov, output bit halted);
    ent_t e;
    bit lg, tr;
    lg = lookup(iv, e);
    inst = iv; run = 1'b1; ofa = 1'b0;
    step();
    chk("fetch.state", state, 1);
    chk_en("fetch.en", 4'b1100);
    chk("fetch.instret", instret, exp_ret);
    chk("fetch.illegal", illegal, 0);
    step();
    chk("dec.state", state, 2);
    chk_en("dec.en", 4'b0000);
    chk("dec.alu_op", alu_op, 3'b010);
    step();
    if (!lg) begin
      chk("ill.state", state, 5);
      chk("ill.illegal", illegal, 1);
      chk_en("ill.en", 4'b0000);
      halted = 1'b1;
      return;
    end
    chk("exec.state", state, 3);
    chk_en("exec.en", 4'b0010);
    chk("exec.alu_op", alu_op, e.op);
    chk("exec.bsel", alu_bsel, e.bsel);
    if (!e.rt) chk("exec.sext", imm_sext, e.sext);
    ofa = ov;
    tr = e.ovc && ov && TRAP;
    step();
    ofa = 1'b0;
    chk("wb.state", state, 4);
    chk_en("wb.en", {3'b000, !tr});
    chk("wb.alu_op", alu_op, e.op);
    chk("wb.bsel", alu_bsel, e.bsel);
    if (!tr) chk("wb.wsel", rf_wsel, e.wsel);
    if (tr) begin
      step();
      chk("trap.state", state, 5);
      chk("trap.illegal", illegal, 1);
      chk_en("trap.en", 4'b0000);
      halted = 1'b1;
      return;
    end
    exp_ret = exp_ret + 16'd1;
    halted = 1'b0;
  endtask

  // After a WB with run low: FETCH without strobes, then IDLE.
  task automatic stop_after_wb();
    run = 1'b0;
    step();
    chk("stop.state", state, 1);
    chk_en("stop.en", 4'b0000);
    chk("stop.instret", instret, exp_ret);
    step();
    chk("stop.idle", state, 0);
  endtask

  initial begin
    bit h;
    ent_t e;
    logic [31:0] v;
    rsta = 1'b1; run = 1'b0; ofa = 1'b0; zfa = 1'b0; inst = '0; exp_ret = '0;
    tbl.push_back('{1'b1, 6'h00, 6'h20, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 6'h00, 6'h22, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 6'h00, 6'h24, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 6'h00, 6'h25, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 6'h00, 6'h26, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 6'h00, 6'h27, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 6'h00, 6'h2A, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 6'h08, 6'h00, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 6'h0A, 6'h00, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h0C, 6'h00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h0D, 6'h00, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 6'h0E, 6'h00, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0});
    step();
    do_reset();
    step();
    chk("idle.hold", state, 0);

    // ADD single instruction
    do_inst(32'h00221820, 1'b0, h);
    stop_after_wb();

    // ANDI then ADDI back-to-back
    do_inst(32'h3022FFFF, 1'b0, h);
    do_inst(32'h2022FFFF, 1'b0, h);
    stop_after_wb();
    chk("b2b.instret", instret, 16'd3);

    // run dropped during DECODE
    inst = 32'h00221825; run = 1'b1;
    step(); chk("rd.fetch", state, 1);
    step(); chk("rd.dec", state, 2);
    run = 1'b0;
    step(); chk("rd.exec", state, 3);
    step(); chk("rd.wb", state, 4); chk_en("rd.wb.en", 4'b0001);
    exp_ret = exp_ret + 16'd1;
    step(); chk("rd.fetch2", state, 1); chk("rd.no_ir", ir_we, 0);
    chk("rd.instret", instret, exp_ret);
    for (int i = 0; i < 3; i++) begin
      step(); chk("rd.idle", state, 0); chk("rd.no_ir2", ir_we, 0);
    end

    // reset during EXEC of SUB
    do_reset();
    inst = 32'h00221822; run = 1'b1;
    step(); step(); step();
    chk("rx.exec", state, 3);
    rsta = 1'b1; run = 1'b0;
    step();
    rsta = 1'b0;
    chk("rx.state", state, 0);
    chk("rx.rf_we", rf_we, 0);
    chk("rx.instret", instret, 0);
    step();
    chk("rx.idle", state, 0);
    chk("rx.rf_we2", rf_we, 0);

    // ADD with overflow in EXEC
    do_inst(32'h00221820, 1'b1, h);
    chk("ovf.halted", h, TRAP);
    if (h) do_reset();
    else stop_after_wb();

    // illegal instruction: HALT persists, rsta clears
    do_reset();
    do_inst(32'hFC000000, 1'b0, h);
    chk("ill.halted", h, 1);
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom);
      step();
      chk("halt.state", state, 5);
      chk("halt.illegal", illegal, 1);
      chk_en("halt.en", 4'b0000);
      chk("halt.instret", instret, 0);
    end
    do_reset();

    // randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(99, 0) < 85) begin
        e = tbl[$urandom_range(tbl.size() - 1, 0)];
        v = $urandom;
        v[31:26] = e.opc;
        if (e.rt) v[5:0] = e.fn;
      end else begin
        v = $urandom;
        if ($urandom_range(1, 0) == 1) v[31:26] = 6'h3F;
        else begin v[31:26] = 6'h00; v[5:0] = 6'h01; end
      end
      do_inst(v, 1'($urandom), h);
      if (h) begin
        step();
        chk("rnd.halt", state, 5);
        do_reset();
      end
    end
    if (state == 3'b100) stop_after_wb();
    step();
    chk("end.idle", state, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
